// File: rtl/mux_scan_pkg.sv
// Shared types for the channel multiplexer/sequencer: FSM encoding and mode values.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAN  = 2'd1,
    SCAN = 2'd2
  } state_e;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/mux_scan_if.sv
// Control, channel data and valid/ready output bundle between the producer side and mux_scan.
interface mux_scan_if #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N_CH)
);

  logic              en;
  logic              mode;
  logic [SEL_W-1:0]  sel_in;
  logic [N_CH*W-1:0] din;
  logic [W-1:0]      dout;
  logic [SEL_W-1:0]  sel_out;
  logic              dout_valid;
  logic              out_ready;
  logic              wrap;
  logic              sel_err;

  modport master (
    output en, mode, sel_in, din, out_ready,
    input  dout, sel_out, dout_valid, wrap, sel_err
  );

  modport slave (
    input  en, mode, sel_in, din, out_ready,
    output dout, sel_out, dout_valid, wrap, sel_err
  );

endinterface

// File: rtl/mux_scan_sel.sv
// Combinational N_CH:1 selector over a packed channel bus; out-of-range selects yield zero.
module mux_scan_sel #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH*W-1:0] din_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [W-1:0]      dout_o
);

  logic [W-1:0] ch [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign ch[gi] = din_i[gi*W +: W];
  end

  // Compare against every legal index so selects >= N_CH fall through to zero.
  always_comb begin
    dout_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_i == SEL_W'(k)) begin
        dout_o = ch[k];
      end
    end
  end

endmodule

// File: rtl/mux_scan.sv
// Registered N_CH-channel multiplexer with manual select or automatic dwell-timed scanning,
// delivering each captured sample over a valid/ready handshake.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N_CH),
  parameter int DWELL = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  mux_scan_if.slave bus
);

  localparam int               CNT_W      = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   N_CH_EXT   = (SEL_W + 1)'(N_CH);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [W-1:0]     dout_q, dout_d;
  logic [SEL_W-1:0] sel_out_q, sel_out_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             sel_err_q, sel_err_d;

  logic             slot_free;
  logic             capture;
  logic [SEL_W-1:0] cap_ch;
  logic [W-1:0]     cap_data;

  assign slot_free = !valid_q || bus.out_ready;
  assign cap_ch    = (state_q == SCAN) ? ptr_q : bus.sel_in;

  mux_scan_sel #(
    .N_CH  (N_CH),
    .W     (W),
    .SEL_W (SEL_W)
  ) u_sel (
    .din_i  (bus.din),
    .sel_i  (cap_ch),
    .dout_o (cap_data)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    dwell_d   = dwell_q;
    wrap_d    = 1'b0;
    sel_err_d = 1'b0;
    capture   = 1'b0;

    // A blocked output slot freezes the whole sequencer, not just the output.
    if (slot_free) begin
      if (!bus.en) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.mode == MODE_SCAN) begin
              state_d = SCAN;
              ptr_d   = '0;
              dwell_d = DWELL_LAST;
            end else begin
              state_d = MAN;
            end
          end
          MAN: begin
            if (bus.mode == MODE_SCAN) begin
              state_d = SCAN;
              ptr_d   = '0;
              dwell_d = DWELL_LAST;
            end else begin
              capture   = 1'b1;
              sel_err_d = ({1'b0, bus.sel_in} >= N_CH_EXT);
            end
          end
          SCAN: begin
            if (bus.mode == MODE_MAN) begin
              state_d = MAN;
            end else if (dwell_q == '0) begin
              capture = 1'b1;
              wrap_d  = (ptr_q == LAST_CH);
              ptr_d   = (ptr_q == LAST_CH) ? '0 : ptr_q + SEL_W'(1);
              dwell_d = DWELL_LAST;
            end else begin
              dwell_d = dwell_q - CNT_W'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    dout_d    = capture ? cap_data : dout_q;
    sel_out_d = capture ? cap_ch : sel_out_q;
    valid_d   = capture || (valid_q && !bus.out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      dwell_q   <= DWELL_LAST;
      dout_q    <= '0;
      sel_out_q <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      dwell_q   <= dwell_d;
      dout_q    <= dout_d;
      sel_out_q <= sel_out_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.sel_out    = sel_out_q;
  assign bus.dout_valid = valid_q;
  assign bus.wrap       = wrap_q;
  assign bus.sel_err    = sel_err_q;

endmodule
